// File: rtl/trashbin_pkg.sv
// Shared constants for the Trashbin core sequencer: FSM state codes,
// memory access width codes, trap causes and the reset instruction.
package trashbin_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_FETCH      = 3'd0;
    localparam seq_state_t ST_FETCH_WAIT = 3'd1;
    localparam seq_state_t ST_EXECUTE    = 3'd2;
    localparam seq_state_t ST_MEM_WAIT   = 3'd3;
    localparam seq_state_t ST_WRITEBACK  = 3'd4;
    localparam seq_state_t ST_TRAPPED    = 3'd5;

    localparam logic [1:0] MEM_BYTE  = 2'd0;
    localparam logic [1:0] MEM_HALF  = 2'd1;
    localparam logic [1:0] MEM_WORD  = 2'd2;
    localparam logic [1:0] MEM_DWORD = 2'd3;

    localparam logic [1:0] TRAP_INVALID    = 2'd0;
    localparam logic [1:0] TRAP_MISALIGNED = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT    = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

endpackage

// File: rtl/trashbin_core_sequencer_if.sv
// Memory-side bus of the Trashbin core sequencer (CpuDataInterface view).
// The sequencer is the master; the memory subsystem is the slave.
interface trashbin_core_sequencer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   AddressBus;
    logic [XLEN-1:0]   DataWriteBus;
    logic [XLEN/8-1:0] ByteEnable;
    logic              ReadAssert;
    logic              WriteAssert;
    logic [XLEN-1:0]   DataReadBus;
    logic              ReadOK;
    logic              WriteOK;

    modport master (
        output AddressBus, DataWriteBus, ByteEnable, ReadAssert, WriteAssert,
        input  DataReadBus, ReadOK, WriteOK
    );

    modport slave (
        input  AddressBus, DataWriteBus, ByteEnable, ReadAssert, WriteAssert,
        output DataReadBus, ReadOK, WriteOK
    );
endinterface

// File: rtl/trashbin_load_align.sv
// Combinational data-side helpers: byte-enable mask, misalignment detect,
// and load lane select with sign/zero extension to XLEN.
module trashbin_load_align
    import trashbin_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        addr_lo_i,
    input  logic [1:0]        width_i,
    input  logic              sign_ext_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] byte_enable_o,
    output logic              misaligned_o,
    output logic [XLEN-1:0]   load_data_o
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    logic [OFFW-1:0] offset_s;
    logic [3:0]      nbytes_s;
    logic [6:0]      nbits_s;
    logic [XLEN-1:0] lane_s;
    logic            ext_bit_s;

    assign offset_s = addr_lo_i[OFFW-1:0];
    assign nbits_s  = {nbytes_s, 3'b000};
    assign lane_s   = rdata_i >> {offset_s, 3'b000};

    // Access size in bytes; a dword on a 32-bit bus is clamped so indexing stays in range
    always_comb begin
        case (width_i)
            MEM_BYTE:  nbytes_s = 4'd1;
            MEM_HALF:  nbytes_s = 4'd2;
            MEM_WORD:  nbytes_s = 4'd4;
            MEM_DWORD: nbytes_s = (XLEN == 64) ? 4'd8 : 4'd4;
            default:   nbytes_s = 4'd4;
        endcase
    end

    // Natural alignment check; dword does not exist on a 32-bit core
    always_comb begin
        case (width_i)
            MEM_BYTE:  misaligned_o = 1'b0;
            MEM_HALF:  misaligned_o = addr_lo_i[0];
            MEM_WORD:  misaligned_o = |addr_lo_i[1:0];
            MEM_DWORD: misaligned_o = (XLEN == 32) ? 1'b1 : |addr_lo_i[2:0];
            default:   misaligned_o = 1'b1;
        endcase
    end

    // Byte lanes covered by the access, starting at the address offset
    always_comb begin
        byte_enable_o = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byte_enable_o[i] = (i >= int'(offset_s)) &&
                               (i < (int'(offset_s) + int'(nbytes_s)));
        end
    end

    // Pick the top bit of the selected lane, then extend it over the unused bits
    always_comb begin
        ext_bit_s   = 1'b0;
        load_data_o = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext_bit_s = (i == (int'(nbits_s) - 1)) ? (sign_ext_i & lane_s[i]) : ext_bit_s;
        end
        for (int i = 0; i < XLEN; i++) begin
            load_data_o[i] = (i < int'(nbits_s)) ? lane_s[i] : ext_bit_s;
        end
    end

endmodule

// File: rtl/trashbin_core_sequencer.sv
// Handshake-driven control sequencer for the Trashbin core. Owns the PC,
// the instruction register and the memory bus; memory stalls as long as
// needed, and bad instructions, misaligned or timed-out accesses trap.
module trashbin_core_sequencer
    import trashbin_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [63:0]     RESET_VECTOR = 64'h0,
    parameter int              MEM_TIMEOUT  = 0
) (
    input  logic                   CoreClock,
    input  logic                   CoreReset,
    trashbin_core_sequencer_if.master bus,
    output logic [31:0]            CurrentInstruction,
    output logic [XLEN-1:0]        ProgramCounter,
    input  logic                   InvalidInstruction,
    input  logic                   IsMemoryRead,
    input  logic                   IsMemoryWrite,
    input  logic                   MemoryAccessSignExtend,
    input  logic                   WritesRegisterFile,
    input  logic                   IsBranchInstruction,
    input  logic                   IsBranchTaken,
    input  logic                   IsJumpInstruction,
    input  logic                   JumpMode,
    input  logic [1:0]             MemoryAccessWidth,
    input  logic [XLEN-1:0]        DecodedImediate,
    input  logic [XLEN-1:0]        RegisterReadPortA,
    input  logic [XLEN-1:0]        RegisterReadPortB,
    input  logic [XLEN-1:0]        AddressCalculationAdder,
    input  logic [XLEN-1:0]        ALU_Result,
    output logic [XLEN-1:0]        RegisterWriteData,
    output logic                   RegisterWriteEnable,
    output logic                   Trap,
    output logic [1:0]             TrapCause
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    seq_state_t        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   load_q, load_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic              trap_q, trap_d;
    logic [1:0]        cause_q, cause_d;

    logic              is_mem_s, is_load_s, is_store_s, mem_ok_s, timeout_s;
    logic [5:0]        fetch_shift_s;
    logic [XLEN-1:0]   fetch_lane_s, jalr_sum_s, pc_next_s, wdata_rep_s;
    logic [NBYTES-1:0] align_be_s;
    logic              align_mis_s;
    logic [XLEN-1:0]   align_load_s;
    logic [XLEN-1:0]   addr_s, wdata_s;
    logic [NBYTES-1:0] be_s;
    logic              read_s, write_s;

    assign is_load_s  = IsMemoryRead;
    assign is_store_s = IsMemoryWrite & ~IsMemoryRead;
    assign is_mem_s   = IsMemoryRead | IsMemoryWrite;
    assign mem_ok_s   = is_load_s ? bus.ReadOK : bus.WriteOK;

    // The OK that arrives on the last permitted wait cycle still wins over the timeout
    assign timeout_s  = (MEM_TIMEOUT != 32'sd0) &&
                        ((wait_cnt_q + 32'd1) == 32'(MEM_TIMEOUT));

    // On a 64-bit bus the instruction sits in the half chosen by PC[2]
    assign fetch_shift_s = (XLEN == 64) ? {pc_q[2], 5'b00000} : 6'd0;
    assign fetch_lane_s  = bus.DataReadBus >> fetch_shift_s;
    assign jalr_sum_s    = RegisterReadPortA + DecodedImediate;

    trashbin_load_align #(.XLEN(XLEN)) u_align (
        .addr_lo_i     (AddressCalculationAdder[2:0]),
        .width_i       (MemoryAccessWidth),
        .sign_ext_i    (MemoryAccessSignExtend),
        .rdata_i       (bus.DataReadBus),
        .byte_enable_o (align_be_s),
        .misaligned_o  (align_mis_s),
        .load_data_o   (align_load_s)
    );

    // Next PC: jumps and taken branches redirect, everything else falls through
    always_comb begin
        if (IsJumpInstruction) begin
            if (JumpMode) begin
                pc_next_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            end else begin
                pc_next_s = pc_q + DecodedImediate;
            end
        end else if (IsBranchInstruction && IsBranchTaken) begin
            pc_next_s = pc_q + DecodedImediate;
        end else begin
            pc_next_s = pc_q + XLEN'(3'd4);
        end
    end

    // Store data is the low lane of port B copied into every lane of the bus
    always_comb begin
        case (MemoryAccessWidth)
            MEM_BYTE: wdata_rep_s = {NBYTES{RegisterReadPortB[7:0]}};
            MEM_HALF: wdata_rep_s = {(NBYTES / 2){RegisterReadPortB[15:0]}};
            MEM_WORD: wdata_rep_s = {(NBYTES / 4){RegisterReadPortB[31:0]}};
            default:  wdata_rep_s = RegisterReadPortB;
        endcase
    end

    // FSM next-state, PC, instruction/load register, wait counter and trap latch
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        load_d     = load_q;
        wait_cnt_d = wait_cnt_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        case (state_q)
            ST_FETCH: begin
                state_d    = ST_FETCH_WAIT;
                wait_cnt_d = 32'd0;
            end
            ST_FETCH_WAIT: begin
                if (bus.ReadOK) begin
                    ir_d    = fetch_lane_s[31:0];
                    state_d = ST_EXECUTE;
                end else if (timeout_s) begin
                    state_d = ST_TRAPPED;
                    trap_d  = 1'b1;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_EXECUTE: begin
                if (InvalidInstruction) begin
                    state_d = ST_TRAPPED;
                    trap_d  = 1'b1;
                    cause_d = TRAP_INVALID;
                end else if (is_mem_s && align_mis_s) begin
                    state_d = ST_TRAPPED;
                    trap_d  = 1'b1;
                    cause_d = TRAP_MISALIGNED;
                end else if (is_mem_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 32'd0;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ok_s) begin
                    load_d  = is_load_s ? align_load_s : load_q;
                    state_d = ST_WRITEBACK;
                end else if (timeout_s) begin
                    state_d = ST_TRAPPED;
                    trap_d  = 1'b1;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_WRITEBACK: begin
                pc_d    = pc_next_s;
                state_d = ST_FETCH;
            end
            ST_TRAPPED: begin
                state_d = ST_TRAPPED;
                trap_d  = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Bus and register-file controls decoded from the registered state
    always_comb begin
        addr_s  = '0;
        wdata_s = '0;
        be_s    = '0;
        read_s  = 1'b0;
        write_s = 1'b0;
        RegisterWriteEnable = 1'b0;
        case (state_q)
            ST_FETCH, ST_FETCH_WAIT: begin
                addr_s = pc_q;
                be_s   = '1;
                read_s = 1'b1;
            end
            ST_MEM_WAIT: begin
                addr_s  = {AddressCalculationAdder[XLEN-1:OFFW], {OFFW{1'b0}}};
                be_s    = align_be_s;
                wdata_s = wdata_rep_s;
                read_s  = is_load_s;
                write_s = is_store_s;
            end
            ST_WRITEBACK: begin
                RegisterWriteEnable = WritesRegisterFile;
            end
            default: begin
                addr_s = '0;
            end
        endcase
    end

    // The memory strobes stay quiet for as long as reset is held
    assign bus.AddressBus   = addr_s;
    assign bus.DataWriteBus = wdata_s;
    assign bus.ByteEnable   = be_s;
    assign bus.ReadAssert   = read_s & ~CoreReset;
    assign bus.WriteAssert  = write_s & ~CoreReset;

    assign RegisterWriteData  = IsMemoryRead ? load_q : ALU_Result;
    assign CurrentInstruction = ir_q;
    assign ProgramCounter     = pc_q;
    assign Trap               = trap_q;
    assign TrapCause          = cause_q;

    // State registers with synchronous reset that overrides any pending wait
    always_ff @(posedge CoreClock) begin
        if (CoreReset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_VECTOR[XLEN-1:0];
            ir_q       <= NOP_INSTRUCTION;
            load_q     <= '0;
            wait_cnt_q <= 32'd0;
            trap_q     <= 1'b0;
            cause_q    <= TRAP_INVALID;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            load_q     <= load_d;
            wait_cnt_q <= wait_cnt_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

endmodule

// File: tb/tb_trashbin_core_sequencer.sv
// Directed self-checking bench for trashbin_core_sequencer (XLEN = 32,
// reset vector 0x100, memory timeout of 8 wait cycles).
module tb_trashbin_core_sequencer;
    import trashbin_pkg::*;

    localparam int XLEN = 32;

    logic CoreClock = 1'b0;
    logic CoreReset = 1'b1;

    trashbin_core_sequencer_if #(.XLEN(XLEN)) bus ();

    logic [31:0]     CurrentInstruction;
    logic [XLEN-1:0] ProgramCounter;
    logic            InvalidInstruction, IsMemoryRead, IsMemoryWrite, MemoryAccessSignExtend;
    logic            WritesRegisterFile, IsBranchInstruction, IsBranchTaken;
    logic            IsJumpInstruction, JumpMode;
    logic [1:0]      MemoryAccessWidth;
    logic [XLEN-1:0] DecodedImediate, RegisterReadPortA, RegisterReadPortB;
    logic [XLEN-1:0] AddressCalculationAdder, ALU_Result, RegisterWriteData;
    logic            RegisterWriteEnable, Trap;
    logic [1:0]      TrapCause;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt;
    int wr_cnt;

    trashbin_core_sequencer #(
        .XLEN(XLEN), .RESET_VECTOR(64'h100), .MEM_TIMEOUT(8)
    ) dut (
        .CoreClock(CoreClock), .CoreReset(CoreReset), .bus(bus),
        .CurrentInstruction(CurrentInstruction), .ProgramCounter(ProgramCounter),
        .InvalidInstruction(InvalidInstruction), .IsMemoryRead(IsMemoryRead),
        .IsMemoryWrite(IsMemoryWrite), .MemoryAccessSignExtend(MemoryAccessSignExtend),
        .WritesRegisterFile(WritesRegisterFile), .IsBranchInstruction(IsBranchInstruction),
        .IsBranchTaken(IsBranchTaken), .IsJumpInstruction(IsJumpInstruction),
        .JumpMode(JumpMode), .MemoryAccessWidth(MemoryAccessWidth),
        .DecodedImediate(DecodedImediate), .RegisterReadPortA(RegisterReadPortA),
        .RegisterReadPortB(RegisterReadPortB), .AddressCalculationAdder(AddressCalculationAdder),
        .ALU_Result(ALU_Result), .RegisterWriteData(RegisterWriteData),
        .RegisterWriteEnable(RegisterWriteEnable), .Trap(Trap), .TrapCause(TrapCause)
    );

    always #5 CoreClock = ~CoreClock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CoreClock);
        #1;
    endtask

    task automatic clr_dec();
        InvalidInstruction = 1'b0; IsMemoryRead = 1'b0; IsMemoryWrite = 1'b0;
        MemoryAccessSignExtend = 1'b0; WritesRegisterFile = 1'b0;
        IsBranchInstruction = 1'b0; IsBranchTaken = 1'b0;
        IsJumpInstruction = 1'b0; JumpMode = 1'b0; MemoryAccessWidth = MEM_BYTE;
        DecodedImediate = '0; RegisterReadPortA = '0; RegisterReadPortB = '0;
        AddressCalculationAdder = '0; ALU_Result = '0;
    endtask

    // Called while in FETCH; returns in EXECUTE. OK arrives after 'extra' empty wait cycles.
    task automatic do_fetch(input logic [31:0] iw, input int extra);
        tick();
        repeat (extra) tick();
        bus.DataReadBus = iw;
        bus.ReadOK = 1'b1;
        tick();
        bus.ReadOK = 1'b0;
    endtask

    task automatic do_reset();
        CoreReset = 1'b1;
        tick();
        tick();
        CoreReset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_dec();
        bus.DataReadBus = '0;
        bus.ReadOK = 1'b0;
        bus.WriteOK = 1'b0;

        // Reset values while reset is held
        CoreReset = 1'b1;
        tick();
        tick();
        chk("rst_read", bus.ReadAssert, 1'b0);
        chk("rst_write", bus.WriteAssert, 1'b0);
        chk("rst_pc", ProgramCounter, 32'h100);
        chk("rst_ir", CurrentInstruction, 32'h0000_0013);
        chk("rst_trap", Trap, 1'b0);
        chk("rst_cause", TrapCause, 2'd0);
        chk("rst_rwe", RegisterWriteEnable, 1'b0);
        CoreReset = 1'b0;
        #1;

        // addi with zero-wait fetch: 4 cycles, PC 0x100 -> 0x104
        WritesRegisterFile = 1'b1;
        ALU_Result = 32'h55;
        chk("t1_fetch_addr", bus.AddressBus, 32'h100);
        chk("t1_fetch_rd", bus.ReadAssert, 1'b1);
        chk("t1_fetch_be", bus.ByteEnable, 4'hF);
        do_fetch(32'h0050_0093, 0);
        chk("t1_ir", CurrentInstruction, 32'h0050_0093);
        chk("t1_exec_rwe", RegisterWriteEnable, 1'b0);
        tick();
        chk("t1_wb_rwe", RegisterWriteEnable, 1'b1);
        chk("t1_wb_rwd", RegisterWriteData, 32'h55);
        chk("t1_wb_pc", ProgramCounter, 32'h100);
        tick();
        chk("t1_pc", ProgramCounter, 32'h104);
        chk("t1_next_addr", bus.AddressBus, 32'h104);

        // lb from 0x203, OK after 3 empty wait cycles
        clr_dec();
        IsMemoryRead = 1'b1; MemoryAccessWidth = MEM_BYTE; MemoryAccessSignExtend = 1'b1;
        AddressCalculationAdder = 32'h203; WritesRegisterFile = 1'b1; ALU_Result = 32'hDEAD;
        do_fetch(32'h2030_0083, 0);
        tick();
        chk("t2_addr", bus.AddressBus, 32'h200);
        chk("t2_be", bus.ByteEnable, 4'b1000);
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ReadAssert) rd_cnt++;
            if (i == 3) begin
                bus.DataReadBus = 32'h8000_0000;
                bus.ReadOK = 1'b1;
            end
            tick();
        end
        bus.ReadOK = 1'b0;
        chk("t2_read_cycles", rd_cnt, 64'd4);
        chk("t2_wb_rd", bus.ReadAssert, 1'b0);
        chk("t2_rwd", RegisterWriteData, 32'hFFFF_FF80);
        chk("t2_rwe", RegisterWriteEnable, 1'b1);
        tick();
        chk("t2_pc", ProgramCounter, 32'h108);

        // JAL 0x108 -> 0x40
        clr_dec();
        IsJumpInstruction = 1'b1; DecodedImediate = 32'hFFFF_FF38;
        WritesRegisterFile = 1'b1; ALU_Result = 32'h10C;
        do_fetch(32'hF39F_F0EF, 0);
        tick();
        chk("t3_rwd", RegisterWriteData, 32'h10C);
        tick();
        chk("t3_pc", ProgramCounter, 32'h40);

        // Taken branch, imm -8: 0x40 -> 0x38
        clr_dec();
        IsBranchInstruction = 1'b1; IsBranchTaken = 1'b1; DecodedImediate = 32'hFFFF_FFF8;
        do_fetch(32'hFE00_0CE3, 0);
        tick();
        chk("t4_rwe", RegisterWriteEnable, 1'b0);
        tick();
        chk("t4_pc", ProgramCounter, 32'h38);

        // Untaken branch: 0x38 -> 0x3C
        IsBranchTaken = 1'b0;
        do_fetch(32'hFE00_1CE3, 0);
        tick();
        tick();
        chk("t5_pc", ProgramCounter, 32'h3C);

        // JALR with A = 0x1001, imm = 2 -> 0x1002
        clr_dec();
        IsJumpInstruction = 1'b1; JumpMode = 1'b1;
        RegisterReadPortA = 32'h1001; DecodedImediate = 32'h2;
        do_fetch(32'h0020_80E7, 0);
        tick();
        tick();
        chk("t6_pc", ProgramCounter, 32'h1002);

        // sb to 0x2005; a ReadOK during the write is ignored
        clr_dec();
        IsMemoryWrite = 1'b1; MemoryAccessWidth = MEM_BYTE;
        AddressCalculationAdder = 32'h2005; RegisterReadPortB = 32'h1234_56AB;
        do_fetch(32'h0020_02A3, 0);
        tick();
        chk("t7_wr", bus.WriteAssert, 1'b1);
        chk("t7_rd", bus.ReadAssert, 1'b0);
        chk("t7_addr", bus.AddressBus, 32'h2004);
        chk("t7_be", bus.ByteEnable, 4'b0010);
        chk("t7_wdata", bus.DataWriteBus, 32'hABAB_ABAB);
        bus.ReadOK = 1'b1;
        tick();
        bus.ReadOK = 1'b0;
        chk("t7_wrong_ok", bus.WriteAssert, 1'b1);
        bus.WriteOK = 1'b1;
        tick();
        bus.WriteOK = 1'b0;
        chk("t7_wb_wr", bus.WriteAssert, 1'b0);
        tick();
        chk("t7_pc", ProgramCounter, 32'h1006);

        // lhu from 0x2002, zero-wait
        clr_dec();
        IsMemoryRead = 1'b1; MemoryAccessWidth = MEM_HALF;
        AddressCalculationAdder = 32'h2002; WritesRegisterFile = 1'b1;
        do_fetch(32'h0020_5083, 0);
        tick();
        chk("t8_be", bus.ByteEnable, 4'b1100);
        bus.DataReadBus = 32'h9ABC_1234;
        bus.ReadOK = 1'b1;
        tick();
        bus.ReadOK = 1'b0;
        chk("t8_rwd", RegisterWriteData, 32'h0000_9ABC);
        tick();
        chk("t8_pc", ProgramCounter, 32'h100A);

        // Fetch OK on exactly the 8th wait cycle: no timeout
        clr_dec();
        WritesRegisterFile = 1'b1; ALU_Result = 32'h77;
        do_fetch(32'h0070_0113, 7);
        chk("t9_trap", Trap, 1'b0);
        chk("t9_ir", CurrentInstruction, 32'h0070_0113);
        tick();
        chk("t9_rwe", RegisterWriteEnable, 1'b1);
        tick();
        chk("t9_pc", ProgramCounter, 32'h100E);

        // Misaligned sh to 0x101 traps without touching the bus
        clr_dec();
        IsMemoryWrite = 1'b1; MemoryAccessWidth = MEM_HALF; AddressCalculationAdder = 32'h101;
        do_fetch(32'h0010_10A3, 0);
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.WriteAssert) wr_cnt++;
            bus.ReadOK = (i == 2);
            tick();
        end
        bus.ReadOK = 1'b0;
        chk("t10_trap", Trap, 1'b1);
        chk("t10_cause", TrapCause, 2'd1);
        chk("t10_no_write", wr_cnt, 64'd0);
        chk("t10_pc", ProgramCounter, 32'h100E);
        chk("t10_rd", bus.ReadAssert, 1'b0);
        chk("t10_ir", CurrentInstruction, 32'h0010_10A3);

        // Fetch timeout after 8 empty wait cycles
        clr_dec();
        do_reset();
        chk("t11_trap_clr", Trap, 1'b0);
        tick();
        repeat (7) tick();
        chk("t11_pre_trap", Trap, 1'b0);
        chk("t11_pre_rd", bus.ReadAssert, 1'b1);
        tick();
        chk("t11_trap", Trap, 1'b1);
        chk("t11_cause", TrapCause, 2'd2);
        chk("t11_rd", bus.ReadAssert, 1'b0);
        chk("t11_pc", ProgramCounter, 32'h100);

        // Invalid instruction takes priority over a misaligned access
        do_reset();
        InvalidInstruction = 1'b1; IsMemoryRead = 1'b1;
        MemoryAccessWidth = MEM_WORD; AddressCalculationAdder = 32'h1;
        do_fetch(32'hFFFF_FFFF, 0);
        tick();
        chk("t12_trap", Trap, 1'b1);
        chk("t12_cause", TrapCause, 2'd0);

        // Reset in the middle of a store wait
        clr_dec();
        do_reset();
        IsMemoryWrite = 1'b1; MemoryAccessWidth = MEM_WORD;
        AddressCalculationAdder = 32'h3000; RegisterReadPortB = 32'hCAFE_F00D;
        do_fetch(32'h0020_A023, 0);
        tick();
        chk("t13_wr", bus.WriteAssert, 1'b1);
        chk("t13_wdata", bus.DataWriteBus, 32'hCAFE_F00D);
        CoreReset = 1'b1;
        tick();
        chk("t13_rst_wr", bus.WriteAssert, 1'b0);
        chk("t13_rst_pc", ProgramCounter, 32'h100);
        chk("t13_rst_ir", CurrentInstruction, 32'h0000_0013);
        CoreReset = 1'b0;
        #1;
        chk("t13_fetch_addr", bus.AddressBus, 32'h100);
        chk("t13_fetch_rd", bus.ReadAssert, 1'b1);
        chk("t13_fetch_wr", bus.WriteAssert, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
